// File: rtl/mul8_sequencer.sv
// 8x8 multiply sequencer that drives one shared external 4x4 multiplier through four nibble phases.
// Define MUL8_SIGNED_EN to add two's-complement operands, selected per operation by in_signed.
module mul8_sequencer #(
  parameter int MUL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic        busy,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_p
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  localparam logic [1:0] LAST_CNT = 2'(MUL_LAT);

  state_t      state;
  logic [7:0]  a_q, b_q;
  logic [1:0]  phase, lat_cnt;
  logic [15:0] acc;

  logic [7:0]  a_mag, b_mag;
  logic [1:0]  next_phase;
  logic [15:0] term, acc_next, result;

`ifdef MUL8_SIGNED_EN
  logic neg_q;

  // Magnitudes are exact in 8 bits unsigned, including |-128| = 128.
  assign a_mag  = (in_signed && in_a[7]) ? -in_a : in_a;
  assign b_mag  = (in_signed && in_b[7]) ? -in_b : in_b;
  assign result = neg_q ? -acc_next : acc_next;
`else
  logic unused_signed;

  assign unused_signed = in_signed;
  assign a_mag         = in_a;
  assign b_mag         = in_b;
  assign result        = acc_next;
`endif

  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign next_phase = phase + 2'd1;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    term = 16'd0;
    case (phase)
      2'd0:    term = {8'd0, mul_p};
      2'd1,
      2'd2:    term = {4'd0, mul_p, 4'd0};
      default: term = {mul_p, 8'd0};
    endcase
    acc_next = acc + term;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_q        <= 8'd0;
      b_q        <= 8'd0;
      phase      <= 2'd0;
      lat_cnt    <= 2'd0;
      acc        <= 16'd0;
      out_valid  <= 1'b0;
      out_result <= 16'd0;
      mul_a      <= 4'd0;
      mul_b      <= 4'd0;
`ifdef MUL8_SIGNED_EN
      neg_q      <= 1'b0;
`endif
    end else if (clr) begin
      state     <= IDLE;
      phase     <= 2'd0;
      lat_cnt   <= 2'd0;
      acc       <= 16'd0;
      out_valid <= 1'b0;
      mul_a     <= 4'd0;
      mul_b     <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a_mag;
            b_q     <= b_mag;
            acc     <= 16'd0;
            phase   <= 2'd0;
            lat_cnt <= 2'd0;
            mul_a   <= a_mag[3:0];
            mul_b   <= b_mag[3:0];
            state   <= MUL;
`ifdef MUL8_SIGNED_EN
            neg_q   <= in_signed & (in_a[7] ^ in_b[7]);
`endif
          end
        end
        MUL: begin
          // Operands stay put for MUL_LAT+1 cycles; the product is taken on the last one.
          if (lat_cnt == LAST_CNT) begin
            acc     <= acc_next;
            lat_cnt <= 2'd0;
            phase   <= next_phase;
            if (phase == 2'd3) begin
              state      <= DONE;
              out_valid  <= 1'b1;
              out_result <= result;
              mul_a      <= 4'd0;
              mul_b      <= 4'd0;
            end else begin
              mul_a <= next_phase[0] ? a_q[7:4] : a_q[3:0];
              mul_b <= next_phase[1] ? b_q[7:4] : b_q[3:0];
            end
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mul8_sequencer.md
Name: mul8_sequencer

Overview:
Sequencer that computes an 8x8 product by time-multiplexing one shared external 4x4 unsigned array multiplier over four partial-product phases, accumulating shifted results into a 16-bit register. Sits between a valid/ready operand source and a valid/ready result sink. Owns the multiplier's operand pins; the multiplier itself is instantiated outside this block.

Parameters:
MUL_LAT, 0, multiplier latency in cycles from mul_a/mul_b change to valid mul_p; legal 0..3.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous abort; returns to IDLE
in_valid  input  1  operand request
in_ready  output  1  operands accepted when in_valid & in_ready
in_a  input  8  multiplicand
in_b  input  8  multiplier
in_signed  input  1  two's-complement operands (used only with the optional feature)
out_valid  output  1  result available
out_ready  input  1  sink accepts the result when out_valid & out_ready
out_result  output  16  product
busy  output  1  high in any state other than IDLE
mul_a  output  4  nibble to external multiplier A input
mul_b  output  4  nibble to external multiplier B input
mul_p  input  8  external multiplier product

Behaviour:
- States: IDLE, MUL, DONE. Reset: IDLE, out_valid=0, out_result=0, accumulator=0, mul_a=mul_b=0, phase=0, busy=0.
- in_ready = (state==IDLE). Decoded, not registered, and does not depend on in_valid.
- IDLE: on handshake, latch in_a/in_b, clear the accumulator, set phase=0, go to MUL.
- MUL: phase p in 0..3 selects operands:
  - p0: aL*bL, shift 0
  - p1: aH*bL, shift 4
  - p2: aL*bH, shift 4
  - p3: aH*bH, shift 8
- mul_a/mul_b are registered and held constant for MUL_LAT+1 cycles per phase. On the last cycle of a phase: acc += zero-extended mul_p << shift; phase++.
- After p3 accumulates, go to DONE. The 16-bit accumulator cannot overflow for unsigned operands.
- mul_a/mul_b are 0 outside MUL.
- Latency: handshake in cycle 0 -> out_valid first high in cycle 4*(MUL_LAT+1)+1.
- DONE: out_valid=1 and out_result=acc, held stable while out_ready=0. On out_ready, go to IDLE and drop out_valid the next cycle.
- No overlap: throughput is one result per 4*(MUL_LAT+1)+2 cycles under continuous demand.
- clr: has priority over every transition. Next state is IDLE; out_valid drops next cycle; the accumulator clears; out_result keeps its last value. clr in IDLE is a no-op. A simultaneous handshake is discarded.
- rst_n low mid-operation: immediate return to reset values; the in-flight product is lost.
- in_a/in_b changes after acceptance have no effect.

Optional Feature:
Macro MUL8_SIGNED_EN.
- Defined: with in_signed=1 at acceptance, latch the operand magnitudes (|-128|=128 fits 8 bits unsigned) and record sign = a[7]^b[7]. On entry to DONE, out_result is acc negated (two's complement) if sign=1. This adds one register bit and one 16-bit negate; latency is unchanged. With in_signed=0 the block is unsigned.
- Undefined: in_signed is present but ignored; all operands are unsigned.

Test Plan:
1. MUL_LAT=0, in_a=0xFF, in_b=0xFF -> (mul_a,mul_b) = (F,F) in cycles 1..4; out_valid in cycle 5; out_result=0xFE01; busy high in cycles 1..5.
2. MUL_LAT=2, in_a=0x12, in_b=0x34 -> mul pairs (2,4),(1,4),(2,3),(1,3), each held 3 cycles; out_valid in cycle 13; out_result=0x03A8.
3. Backpressure: 0x0F*0x10, out_ready=0 for 3 cycles after out_valid -> out_result=0x00F0 stable, in_ready=0, and a new in_valid is not accepted. Release -> IDLE next cycle; the following op 0x02*0x03 gives 0x0006.
4. clr during phase 2 of 0xAA*0x55 -> IDLE next cycle, no out_valid. The next op 0x07*0x09 gives 0x003F with correct latency. Repeat with rst_n low mid-op -> all outputs at reset values.
5. Signed, macro defined, in_signed=1: 0x80*0x7F -> 0xC080 (-16256); 0xFF*0xFF -> 0x0001. Macro undefined, same stimulus: 0x80*0x7F -> 0x3F80.
6. Randomized back-to-back stream of 200 operand pairs with random in_valid/out_ready, MUL_LAT in {0,1,3} -> every result equals the reference product, in order, with none dropped or duplicated.
